led_matrix_driver: RTL and testbench

//  Row-multiplexed driver for the 8x8 LED overlay under the board squares: the output

---
 rtl/led_matrix_driver.sv | 135 +++++++++++++
 tb/tb_led_matrix_driver.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/led_matrix_driver.sv
// Row-multiplexed 8x8 LED driver: double-buffered frame intake, per-row blanking,
// and 16-slot PWM brightness inside each row dwell.
module led_matrix_driver #(
  parameter int unsigned SLOT_CYCLES  = 7812,
  parameter int unsigned BLANK_CYCLES = 100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] frame_in,
  input  logic        frame_valid,
  output logic        frame_ready,
  input  logic [3:0]  brightness,
  output logic [2:0]  row_sel,
  output logic        row_en,
  output logic [7:0]  col_out,
  output logic        frame_loaded
);

  localparam int unsigned BW = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
  localparam int unsigned SW = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;

  typedef enum logic {ST_BLANK, ST_DRIVE} state_e;

  state_e         state_q, state_d;
  logic [BW-1:0]  blank_cnt_q, blank_cnt_d;
  logic [SW-1:0]  slot_cnt_q, slot_cnt_d;
  logic [3:0]     slot_idx_q, slot_idx_d;
  logic [3:0]     br_q, br_d;
  logic [2:0]     row_sel_q, row_sel_d;
  logic           row_en_q, row_en_d;
  logic [7:0]     col_out_q, col_out_d;
  logic           frame_ready_q, frame_ready_d;
  logic           frame_loaded_q, frame_loaded_d;
  logic [63:0]    active_q, active_d;
  logic [63:0]    shadow_q, shadow_d;
  logic           pending_q, pending_d;

  // Next-state, buffer handover and registered-output values
  always_comb begin
    state_d        = state_q;
    blank_cnt_d    = blank_cnt_q;
    slot_cnt_d     = slot_cnt_q;
    slot_idx_d     = slot_idx_q;
    br_d           = br_q;
    row_sel_d      = row_sel_q;
    active_d       = active_q;
    shadow_d       = shadow_q;
    pending_d      = pending_q;
    frame_loaded_d = 1'b0;

    if (frame_valid && frame_ready_q) begin
      shadow_d  = frame_in;
      pending_d = 1'b1;
    end

    case (state_q)
      ST_BLANK: begin
        if (blank_cnt_q == BW'(BLANK_CYCLES - 1)) begin
          blank_cnt_d = '0;
          slot_cnt_d  = '0;
          slot_idx_d  = '0;
          br_d        = brightness;
          state_d     = ST_DRIVE;
          // New frames only swap in at the row-0 boundary to avoid tearing
          if ((row_sel_q == 3'd0) && pending_q) begin
            active_d       = shadow_q;
            pending_d      = 1'b0;
            frame_loaded_d = 1'b1;
          end
        end else begin
          blank_cnt_d = blank_cnt_q + BW'(1);
        end
      end
      ST_DRIVE: begin
        if (slot_cnt_q == SW'(SLOT_CYCLES - 1)) begin
          slot_cnt_d = '0;
          if (slot_idx_q == 4'd15) begin
            slot_idx_d = '0;
            row_sel_d  = row_sel_q + 3'd1;
            state_d    = ST_BLANK;
          end else begin
            slot_idx_d = slot_idx_q + 4'd1;
          end
        end else begin
          slot_cnt_d = slot_cnt_q + SW'(1);
        end
      end
      default: state_d = ST_BLANK;
    endcase

    frame_ready_d = ~pending_d;
    row_en_d      = (state_d == ST_BLANK);
    col_out_d     = ((state_d == ST_DRIVE) && (slot_idx_d < br_d)) ?
                    ~active_d[{row_sel_d, 3'b000} +: 8] : 8'hFF;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_BLANK;
      blank_cnt_q    <= '0;
      slot_cnt_q     <= '0;
      slot_idx_q     <= '0;
      br_q           <= '0;
      row_sel_q      <= '0;
      row_en_q       <= 1'b1;
      col_out_q      <= 8'hFF;
      frame_ready_q  <= 1'b1;
      frame_loaded_q <= 1'b0;
      active_q       <= '0;
      shadow_q       <= '0;
      pending_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      blank_cnt_q    <= blank_cnt_d;
      slot_cnt_q     <= slot_cnt_d;
      slot_idx_q     <= slot_idx_d;
      br_q           <= br_d;
      row_sel_q      <= row_sel_d;
      row_en_q       <= row_en_d;
      col_out_q      <= col_out_d;
      frame_ready_q  <= frame_ready_d;
      frame_loaded_q <= frame_loaded_d;
      active_q       <= active_d;
      shadow_q       <= shadow_d;
      pending_q      <= pending_d;
    end
  end

  assign frame_ready  = frame_ready_q;
  assign row_sel      = row_sel_q;
  assign row_en       = row_en_q;
  assign col_out      = col_out_q;
  assign frame_loaded = frame_loaded_q;

endmodule

// File: tb/tb_led_matrix_driver.sv
// Bench for led_matrix_driver: accepted frames queue up and are retired at the
// row-0 load point; every cycle is compared against a row/slot timing model.
module tb_led_matrix_driver;

  localparam int SLOT  = 4;
  localparam int BLANK = 2;
  localparam int ROWP  = BLANK + 16 * SLOT;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [63:0] frame_in = '0;
  logic        frame_valid = 1'b0;
  logic        frame_ready;
  logic [3:0]  brightness = 4'd0;
  logic [2:0]  row_sel;
  logic        row_en;
  logic [7:0]  col_out;
  logic        frame_loaded;

  int checks = 0;
  int failures = 0;

  led_matrix_driver #(.SLOT_CYCLES(SLOT), .BLANK_CYCLES(BLANK)) dut (
    .clk(clk), .rst(rst), .frame_in(frame_in), .frame_valid(frame_valid),
    .frame_ready(frame_ready), .brightness(brightness), .row_sel(row_sel),
    .row_en(row_en), .col_out(col_out), .frame_loaded(frame_loaded)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard and timing model, advanced once per clock
  logic [63:0] sb_q[$];
  logic [63:0] disp = '0;
  logic [3:0]  br_m = '0;
  logic        pend = 1'b0;
  logic        exp_load = 1'b0;
  bit          started = 1'b0;
  int          t = 0;

  always @(posedge clk) begin
    logic        r_s, v_s, acc, ld;
    logic [63:0] f_s;
    logic [3:0]  b_s;
    logic [7:0]  exp_col;
    int          p, row;
    r_s = rst; v_s = frame_valid; f_s = frame_in; b_s = brightness;
    #1;
    if (r_s) begin
      t = 0; pend = 1'b0; disp = '0; br_m = '0; exp_load = 1'b0;
      sb_q.delete();
      started = 1'b1;
    end else if (started) begin
      p   = t % ROWP;
      row = (t / ROWP) % 8;
      acc = v_s && !pend;
      ld  = (p == BLANK - 1) && (row == 0) && pend;
      if (acc) begin
        sb_q.push_back(f_s);
        pend = 1'b1;
      end
      exp_load = ld;
      if (ld) begin
        pend = 1'b0;
        check("queue_nonempty_at_load", 64'(sb_q.size() != 0), 64'd1);
        if (sb_q.size() != 0) disp = sb_q.pop_front();
      end
      if (p == BLANK - 1) br_m = b_s;
      t++;
    end
    if (started) begin
      p   = t % ROWP;
      row = (t / ROWP) % 8;
      exp_col = 8'hFF;
      if (p >= BLANK && ((p - BLANK) / SLOT) < int'(br_m))
        exp_col = ~disp[row*8 +: 8];
      check("row_en", 64'(row_en), 64'(p < BLANK));
      check("row_sel", 64'(row_sel), 64'(row));
      check("col_out", 64'(col_out), 64'(exp_col));
      check("frame_ready", 64'(frame_ready), 64'(!pend));
      check("frame_loaded", 64'(frame_loaded), 64'(exp_load));
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic offer(input logic [63:0] f);
    @(negedge clk);
    frame_valid = 1'b1;
    frame_in    = f;
    @(negedge clk);
    frame_valid = 1'b0;
  endtask

  task automatic wait_loaded(input int budget);
    int n = 0;
    while (!frame_loaded && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("wait_frame_loaded_timeout", 64'(n < budget), 64'd1);
  endtask

  task automatic wait_row5_drive(input int budget);
    int n = 0;
    while (!(row_sel == 3'd5 && row_en == 1'b0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("wait_row5_timeout", 64'(n < budget), 64'd1);
  endtask

  initial begin
    // Reset and idle display
    @(negedge clk);
    rst = 1'b1;
    cycles(2);
    rst = 1'b0;
    brightness = 4'd15;
    cycles(70);

    // Single-row pattern at full brightness
    offer(64'h00000000000000A5);
    cycles(2 * 8 * ROWP);

    // All-ones at half brightness, then brightness 0
    brightness = 4'd8;
    offer(64'hFFFFFFFFFFFFFFFF);
    cycles(2 * 8 * ROWP);
    brightness = 4'd0;
    cycles(8 * ROWP);

    // Double buffering: A shown, B accepted during row 3, C refused
    brightness = 4'd15;
    offer(64'h0123456789ABCDEF);
    wait_loaded(2 * 8 * ROWP);
    cycles(3 * ROWP + 10);
    offer(64'hF0E1D2C3B4A59687);
    cycles(5);
    frame_valid = 1'b1;
    frame_in    = 64'hDEADBEEFCAFEF00D;
    cycles(20);
    frame_valid = 1'b0;
    cycles(2 * 8 * ROWP + 50);

    // Reset mid-row-5 with a frame pending
    brightness = 4'd11;
    wait_row5_drive(8 * ROWP + 10);
    offer(64'h5555AAAA3333CCCC);
    cycles(5);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    cycles(8 * ROWP + 80);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
